kc_tap_loader: RTL and testbench
================================

// Module: kc_tap_loader
// PURPOSE
//  Consumer end of the hps_io ioctl download stream for the "Load Tape" (TAP) OSD entry.
//  Parses a KC85 TAP image: 16-byte signature, then 129-byte blocks (block no. + 128 data).
//  Block 1 is the KC file header; later blocks are written into core RAM via a req/ack port.
//  Drives ioctl_wait to stall the HPS while a RAM write is pending; reports the exec address.
// PARAMETERS
//  TAP_INDEX  8'd1   ioctl_index value that selects this loader
//  BLK_LEN    128    data bytes per TAP block (block-number byte not included)
// PORTS
//  clk_sys         in   1   system clock
//  reset_n         in   1   asynchronous, active-low reset
//  ioctl_download  in   1   download in progress (from hps_io)
//  ioctl_index     in   8   file index of the current download
//  ioctl_wr        in   1   byte strobe, one clk_sys cycle
//  ioctl_addr      in   25  byte offset; unused, bytes arrive in address order
//  ioctl_data      in   8   download byte
//  ioctl_wait      out  1   back-pressure to hps_io; high = hold next ioctl_wr
//  mem_addr        out  16  RAM write address
//  mem_data        out  8   RAM write data
//  mem_wr          out  1   RAM write request; held until mem_ack
//  mem_ack         in   1   RAM write done, single-cycle pulse
//  exec_addr       out  16  exec address from the KC header
//  exec_valid      out  1   exec_addr valid: header arg count >= 3 and load completed
//  autostart       out  1   1-cycle pulse at successful end of load when exec_valid
//  busy            out  1   parser active (state != IDLE/DONE/ERR)
//  err             out  1   bad signature, end <= load address, or truncated header
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE. Reset mid-load abandons the load: no further mem_wr, wait low.
//  sel = ioctl_download && ioctl_index==TAP_INDEX. Byte accepted = sel && ioctl_wr && !ioctl_wait.
//  Rising edge of sel: clear err, exec_valid, exec_addr, counters; enter SIG.
//  States:
//   SIG   : byte k (0..15) compared to "\xC3KC-TAPE by AF. "; mismatch -> ERR; byte 15 ok -> BLKNO.
//   BLKNO : block-number byte, value ignored; byte index := 0; -> HDR (first block) else DATA.
//   HDR   : data byte 16 = arg count; 17/18 = load lo/hi; 19/20 = end lo/hi (exclusive);
//           21/22 = exec lo/hi; others ignored. After byte 127: end<=load -> ERR, else
//           cur_addr := load; -> BLKNO.
//   DATA  : if cur_addr < end: mem_addr<=cur_addr, mem_data<=byte, mem_wr<=1 next cycle,
//           ioctl_wait<=1 same edge; -> WAITMEM. Else byte discarded (padding), no stall.
//           After the 128th data byte of the block -> BLKNO.
//   WAITMEM: hold mem_wr/addr/data and ioctl_wait. On mem_ack: mem_wr<=0, ioctl_wait<=0,
//           cur_addr+=1; return to DATA or BLKNO per byte index. Stall length = ack delay.
//   DONE/ERR: absorb bytes with no effect until the next rising edge of sel.
//  Falling edge of sel:
//   - in WAITMEM: the pending write completes first (mem_wr held to ack); end handling follows.
//   - from DATA/BLKNO after the header was parsed: -> DONE; exec_valid := (args>=3);
//     autostart pulses 1 cycle later if exec_valid. Partial data (cur_addr<end) still -> DONE.
//   - from SIG or HDR: -> ERR (truncated).
//  err is sticky until the next load starts. ioctl_wait never high outside WAITMEM.
//  cur_addr is 16-bit; end is exclusive, so at most 0xFFFF bytes are written, no wrap.
//  Simultaneous mem_ack and falling sel: the ack completes the write, then DONE the same cycle.
//  Downloads with another ioctl_index: ignored entirely, outputs unchanged, wait low.
// TESTING
//  1 Valid TAP, load=0x0300 end=0x0305 exec=0x0300 args=3, data 0x11.. -> 5 writes
//    0x0300..0x0304 = 0x11..0x15, no write for padding, exec_addr=0x0300, exec_valid=1,
//    one autostart pulse after download falls.
//  2 Signature byte 0 = 0x00 -> err=1 after that byte, no mem_wr, autostart never pulses.
//  3 mem_ack delayed 5 cycles each -> ioctl_wait high >=5 cycles per write, all bytes
//    written in order, no byte lost or duplicated.
//  4 Header args=2 -> all writes done, exec_valid=0, no autostart.
//  5 Download with ioctl_index=0 -> no mem_wr, wait=0, busy=0.
//  6 reset_n low during DATA with mem_wr pending -> all outputs 0 immediately; next
//    valid download completes cleanly as in test 1.

Source files
------------

// File: rtl/kc_tap_loader.sv
// KC85 TAP loader: consumes the hps_io ioctl byte stream, checks the TAP signature,
// parses the KC file header and writes program blocks into core RAM over a req/ack port.
module kc_tap_loader #(
  parameter logic [7:0] TAP_INDEX = 8'd1,
  parameter int         BLK_LEN   = 128
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic [15:0] exec_addr,
  output logic        exec_valid,
  output logic        autostart,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SIG     = 3'd1,
    ST_BLKNO   = 3'd2,
    ST_HDR     = 3'd3,
    ST_DATA    = 3'd4,
    ST_WAITMEM = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(BLK_LEN - 1);
  localparam logic [7:0] BLK_END  = 8'(BLK_LEN);

  function automatic logic [7:0] sig_byte(input logic [3:0] k);
    case (k)
      4'd0:    sig_byte = 8'hC3;
      4'd1:    sig_byte = 8'h4B;
      4'd2:    sig_byte = 8'h43;
      4'd3:    sig_byte = 8'h2D;
      4'd4:    sig_byte = 8'h54;
      4'd5:    sig_byte = 8'h41;
      4'd6:    sig_byte = 8'h50;
      4'd7:    sig_byte = 8'h45;
      4'd8:    sig_byte = 8'h20;
      4'd9:    sig_byte = 8'h62;
      4'd10:   sig_byte = 8'h79;
      4'd11:   sig_byte = 8'h20;
      4'd12:   sig_byte = 8'h41;
      4'd13:   sig_byte = 8'h46;
      4'd14:   sig_byte = 8'h2E;
      4'd15:   sig_byte = 8'h20;
      default: sig_byte = 8'h00;
    endcase
  endfunction

  state_t      state_r, state_nx;
  logic        sel_s, sel_d_r, rise_s, fall_s, accept_s;
  logic        do_start_s, do_end_s;
  logic [7:0]  idx_r, idx_nx;
  logic        hdr_done_r, hdr_done_nx;
  logic [7:0]  args_r, args_nx;
  logic [15:0] load_r, load_nx, end_r, end_nx, cur_r, cur_nx;
  logic [15:0] exec_addr_r, exec_nx;
  logic [15:0] mem_addr_r, mem_addr_nx;
  logic [7:0]  mem_data_r, mem_data_nx;
  logic        mem_wr_r, mem_wr_nx, wait_r, wait_nx;
  logic        err_r, err_nx, exec_valid_r, exec_valid_nx;
  logic        rise_pend_r, rise_pend_nx, fall_pend_r, fall_pend_nx;
  logic        start_pend_r, start_pend_nx, autostart_r, autostart_nx;
  logic        busy_r, busy_nx;
  logic        unused_addr_s;

  // Bytes arrive in address order, so the offset itself carries no information.
  assign unused_addr_s = ^ioctl_addr;

  assign sel_s    = ioctl_download && (ioctl_index == TAP_INDEX);
  assign rise_s   = sel_s && !sel_d_r;
  assign fall_s   = !sel_s && sel_d_r;
  assign accept_s = sel_s && ioctl_wr && !wait_r;

  // Next-state, datapath and output decode for the loader.
  always_comb begin
    state_nx      = state_r;
    idx_nx        = idx_r;
    hdr_done_nx   = hdr_done_r;
    args_nx       = args_r;
    load_nx       = load_r;
    end_nx        = end_r;
    cur_nx        = cur_r;
    exec_nx       = exec_addr_r;
    mem_addr_nx   = mem_addr_r;
    mem_data_nx   = mem_data_r;
    mem_wr_nx     = mem_wr_r;
    wait_nx       = wait_r;
    err_nx        = err_r;
    exec_valid_nx = exec_valid_r;
    rise_pend_nx  = rise_pend_r;
    fall_pend_nx  = fall_pend_r;
    start_pend_nx = 1'b0;
    autostart_nx  = start_pend_r;
    do_start_s    = 1'b0;
    do_end_s      = 1'b0;
    busy_nx       = 1'b0;

    if (state_r == ST_WAITMEM) begin
      // sel edges seen during a pending write are replayed once the write completes
      rise_pend_nx = rise_pend_r | rise_s;
      fall_pend_nx = fall_pend_r | fall_s;
      if (mem_ack) begin
        mem_wr_nx    = 1'b0;
        wait_nx      = 1'b0;
        cur_nx       = cur_r + 16'd1;
        rise_pend_nx = 1'b0;
        fall_pend_nx = 1'b0;
        if (idx_r == BLK_END) begin
          state_nx = ST_BLKNO;
        end else begin
          state_nx = ST_DATA;
        end
        if (rise_pend_r || rise_s) begin
          do_start_s = 1'b1;
        end else if (fall_pend_r || fall_s) begin
          do_end_s = 1'b1;
        end else begin
          do_end_s = 1'b0;
        end
      end else begin
        mem_wr_nx = 1'b1;
      end
    end else if (rise_s) begin
      do_start_s = 1'b1;
    end else if (fall_s) begin
      do_end_s = 1'b1;
    end else if (accept_s) begin
      case (state_r)
        ST_SIG: begin
          if (ioctl_data == sig_byte(idx_r[3:0])) begin
            if (idx_r == 8'd15) begin
              state_nx = ST_BLKNO;
              idx_nx   = 8'd0;
            end else begin
              idx_nx = idx_r + 8'd1;
            end
          end else begin
            state_nx = ST_ERR;
            err_nx   = 1'b1;
          end
        end
        ST_BLKNO: begin
          idx_nx = 8'd0;
          if (hdr_done_r) begin
            state_nx = ST_DATA;
          end else begin
            state_nx = ST_HDR;
          end
        end
        ST_HDR: begin
          idx_nx = idx_r + 8'd1;
          case (idx_r)
            8'd16:   args_nx        = ioctl_data;
            8'd17:   load_nx[7:0]   = ioctl_data;
            8'd18:   load_nx[15:8]  = ioctl_data;
            8'd19:   end_nx[7:0]    = ioctl_data;
            8'd20:   end_nx[15:8]   = ioctl_data;
            8'd21:   exec_nx[7:0]   = ioctl_data;
            8'd22:   exec_nx[15:8]  = ioctl_data;
            default: args_nx        = args_r;
          endcase
          if (idx_r == LAST_IDX) begin
            hdr_done_nx = 1'b1;
            if (end_r <= load_r) begin
              state_nx = ST_ERR;
              err_nx   = 1'b1;
            end else begin
              cur_nx   = load_r;
              state_nx = ST_BLKNO;
            end
          end else begin
            hdr_done_nx = hdr_done_r;
          end
        end
        ST_DATA: begin
          idx_nx = idx_r + 8'd1;
          if (cur_r < end_r) begin
            mem_addr_nx = cur_r;
            mem_data_nx = ioctl_data;
            mem_wr_nx   = 1'b1;
            wait_nx     = 1'b1;
            state_nx    = ST_WAITMEM;
          end else if (idx_r == LAST_IDX) begin
            state_nx = ST_BLKNO;
          end else begin
            state_nx = ST_DATA;
          end
        end
        default: state_nx = state_r;
      endcase
    end else begin
      state_nx = state_r;
    end

    if (do_start_s) begin
      state_nx      = ST_SIG;
      idx_nx        = 8'd0;
      hdr_done_nx   = 1'b0;
      args_nx       = 8'd0;
      load_nx       = 16'd0;
      end_nx        = 16'd0;
      cur_nx        = 16'd0;
      exec_nx       = 16'd0;
      err_nx        = 1'b0;
      exec_valid_nx = 1'b0;
      rise_pend_nx  = 1'b0;
      fall_pend_nx  = 1'b0;
    end else if (do_end_s) begin
      case (state_nx)
        ST_DATA, ST_BLKNO: begin
          if (hdr_done_r) begin
            state_nx      = ST_DONE;
            exec_valid_nx = (args_r >= 8'd3);
            start_pend_nx = (args_r >= 8'd3);
          end else begin
            state_nx = ST_ERR;
            err_nx   = 1'b1;
          end
        end
        ST_SIG, ST_HDR: begin
          state_nx = ST_ERR;
          err_nx   = 1'b1;
        end
        default: state_nx = state_nx;
      endcase
    end else begin
      do_end_s = 1'b0;
    end

    case (state_nx)
      ST_SIG, ST_BLKNO, ST_HDR, ST_DATA, ST_WAITMEM: busy_nx = 1'b1;
      default:                                       busy_nx = 1'b0;
    endcase
  end

  // Parser state, header fields and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      sel_d_r      <= 1'b0;
      idx_r        <= 8'd0;
      hdr_done_r   <= 1'b0;
      args_r       <= 8'd0;
      load_r       <= 16'd0;
      end_r        <= 16'd0;
      cur_r        <= 16'd0;
      exec_addr_r  <= 16'd0;
      mem_addr_r   <= 16'd0;
      mem_data_r   <= 8'd0;
      mem_wr_r     <= 1'b0;
      wait_r       <= 1'b0;
      err_r        <= 1'b0;
      exec_valid_r <= 1'b0;
      rise_pend_r  <= 1'b0;
      fall_pend_r  <= 1'b0;
      start_pend_r <= 1'b0;
      autostart_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx;
      sel_d_r      <= sel_s;
      idx_r        <= idx_nx;
      hdr_done_r   <= hdr_done_nx;
      args_r       <= args_nx;
      load_r       <= load_nx;
      end_r        <= end_nx;
      cur_r        <= cur_nx;
      exec_addr_r  <= exec_nx;
      mem_addr_r   <= mem_addr_nx;
      mem_data_r   <= mem_data_nx;
      mem_wr_r     <= mem_wr_nx;
      wait_r       <= wait_nx;
      err_r        <= err_nx;
      exec_valid_r <= exec_valid_nx;
      rise_pend_r  <= rise_pend_nx;
      fall_pend_r  <= fall_pend_nx;
      start_pend_r <= start_pend_nx;
      autostart_r  <= autostart_nx;
      busy_r       <= busy_nx;
    end
  end

  assign ioctl_wait = wait_r;
  assign mem_addr   = mem_addr_r;
  assign mem_data   = mem_data_r;
  assign mem_wr     = mem_wr_r;
  assign exec_addr  = exec_addr_r;
  assign exec_valid = exec_valid_r;
  assign autostart  = autostart_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_kc_tap_loader.sv
// Bench for kc_tap_loader: TAP images are built in the bench, streamed byte by byte,
// and RAM writes/status are compared with what the image content implies.
module tb_kc_tap_loader;

  localparam logic [7:0] TAP_IDX = 8'd1;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack;
  logic [15:0] exec_addr;
  logic        exec_valid;
  logic        autostart;
  logic        busy;
  logic        err;

  kc_tap_loader #(.TAP_INDEX(TAP_IDX), .BLK_LEN(128)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack), .exec_addr(exec_addr),
    .exec_valid(exec_valid), .autostart(autostart), .busy(busy), .err(err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int stall_min = 0;
  int as_cnt = 0, wr_cycles = 0, wait_viol = 0, busy_cycles = 0, short_stall = 0;
  logic [7:0]  sig_ref [16];
  logic [7:0]  img [$];
  logic [23:0] exp_q [$];
  logic [23:0] got_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // RAM model: acks each request after ack_delay cycles and logs {addr,data}.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      if (!reset_n || mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_wr === 1'b1) begin
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          got_q.push_back({mem_addr, mem_data});
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Observers sampled on the falling edge.
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk_sys);
      if (autostart === 1'b1) as_cnt++;
      if (mem_wr === 1'b1) wr_cycles++;
      if (ioctl_wait !== mem_wr) wait_viol++;
      if (busy === 1'b1) busy_cycles++;
      if (ioctl_wait === 1'b1) begin
        run++;
      end else begin
        if (run > 0 && run < stall_min) short_stall++;
        run = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 2000) begin cyc(1); n++; end
    if (n >= 2000) chk("wait_bound", 32'(n), 32'd0);
    ioctl_data = b;
    ioctl_wr = 1'b1;
    cyc(1);
    ioctl_wr = 1'b0;
    cyc($urandom_range(0, 2));
  endtask

  // Reference image: signature, header block, nblk data blocks; exp_q gets the writes.
  task automatic build(input int args, input int ld, input int en, input int ex,
                       input int nblk, input bit inc);
    logic [7:0] d;
    img.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) img.push_back(sig_ref[i]);
    img.push_back(8'h01);
    for (int i = 0; i < 128; i++) begin
      case (i)
        16:      d = 8'(args);
        17:      d = 8'(ld);
        18:      d = 8'(ld >> 8);
        19:      d = 8'(en);
        20:      d = 8'(en >> 8);
        21:      d = 8'(ex);
        22:      d = 8'(ex >> 8);
        default: d = 8'($urandom);
      endcase
      img.push_back(d);
    end
    for (int b = 0; b < nblk; b++) begin
      img.push_back(8'(b + 2));
      for (int i = 0; i < 128; i++) begin
        d = inc ? 8'(8'h11 + i) : 8'($urandom);
        img.push_back(d);
        if (b * 128 + i < en - ld) exp_q.push_back({16'(ld + b * 128 + i), d});
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [7:0] idx, input int nsend,
                         input int err_at, input logic exp_err, input logic exp_ev,
                         input int exp_as, input logic [15:0] exp_exec);
    int g0, a0, w0, v0, b0, s0, n, ng;
    g0 = got_q.size(); a0 = as_cnt; w0 = wr_cycles; v0 = wait_viol;
    b0 = busy_cycles; s0 = short_stall;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    cyc(2);
    for (int i = 0; i < nsend; i++) begin
      ioctl_addr = 25'(i);
      send_byte(img[i]);
      if (i == err_at) chk({tag, "_err_now"}, 32'(err), 32'd1);
    end
    ioctl_download = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin cyc(1); n++; end
    if (n >= 3000) chk({tag, "_busy_bound"}, 32'(n), 32'd0);
    cyc(4);
    ng = got_q.size() - g0;
    chk({tag, "_nwrites"}, 32'(ng), 32'(exp_q.size()));
    for (int i = 0; i < ng && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_exec_valid"}, 32'(exec_valid), 32'(exp_ev));
    chk({tag, "_exec_addr"}, 32'(exec_addr), 32'(exp_exec));
    chk({tag, "_autostart"}, 32'(as_cnt - a0), 32'(exp_as));
    chk({tag, "_wait_vs_wr"}, 32'(wait_viol - v0), 32'd0);
    chk({tag, "_short_stall"}, 32'(short_stall - s0), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    if (idx != TAP_IDX) begin
      chk({tag, "_busy_cycles"}, 32'(busy_cycles - b0), 32'd0);
      chk({tag, "_wr_cycles"}, 32'(wr_cycles - w0), 32'd0);
    end
  endtask

  initial begin
    int args, ld, en, ex, nblk, g0;
    logic e_err, e_ev;
    sig_ref = '{8'hC3, 8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                8'h20, 8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20};
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_data = 8'd0;
    cyc(3);
    chk("rst_mem", 32'({mem_addr, mem_data, mem_wr}), 32'd0);
    chk("rst_ctl", 32'({exec_addr, ioctl_wait, exec_valid, autostart, busy, err}), 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Reference load: five bytes at 0x0300 then padding.
    build(3, 16'h0300, 16'h0305, 16'h0300, 1, 1'b1);
    do_load("t1", TAP_IDX, img.size(), -1, 1'b0, 1'b1, 1, 16'h0300);

    // Foreign index: nothing happens and status is kept.
    build(3, 16'h1000, 16'h1010, 16'h1000, 1, 1'b0);
    exp_q.delete();
    do_load("t5", 8'd0, img.size(), -1, 1'b0, 1'b1, 0, 16'h0300);

    // Bad first signature byte.
    build(3, 16'h2000, 16'h2010, 16'h2000, 1, 1'b0);
    img[0] = 8'h00;
    exp_q.delete();
    do_load("t2", TAP_IDX, img.size(), 0, 1'b1, 1'b0, 0, 16'h0000);

    // Slow RAM: every write stalls for at least the ack delay.
    ack_delay = 5; stall_min = 5;
    build(4, 16'h4000, 16'h4000 + 140, 16'h4010, 2, 1'b0);
    do_load("t3", TAP_IDX, img.size(), -1, 1'b0, 1'b1, 1, 16'h4010);

    // Too few header args.
    ack_delay = 1; stall_min = 1;
    build(2, 16'h5000, 16'h5020, 16'h5000, 1, 1'b0);
    do_load("t4", TAP_IDX, img.size(), -1, 1'b0, 1'b0, 0, 16'h5000);

    // Truncated inside the header.
    build(3, 16'h6000, 16'h6020, 16'h6004, 1, 1'b0);
    exp_q.delete();
    do_load("trunc", TAP_IDX, 16 + 1 + 40, -1, 1'b1, 1'b0, 0, 16'h6004);

    // Download ends while a write is pending: it completes, then DONE with partial data.
    ack_delay = 5; stall_min = 5;
    build(4, 16'h7000, 16'h7000 + 200, 16'h7000, 2, 1'b0);
    while (exp_q.size() > 10) exp_q.pop_back();
    do_load("fall_wait", TAP_IDX, 16 + 129 + 1 + 10, -1, 1'b0, 1'b1, 1, 16'h7000);

    // Top of the address space.
    ack_delay = 0; stall_min = 0;
    build(3, 16'hFFF0, 16'hFFFF, 16'hFFF0, 1, 1'b0);
    do_load("top", TAP_IDX, img.size(), -1, 1'b0, 1'b1, 1, 16'hFFF0);

    // Randomized loads, including end <= load.
    for (int r = 0; r < 8; r++) begin
      args = $urandom_range(0, 5);
      ld = $urandom_range(16, 16'hFF00);
      ex = $urandom_range(0, 16'hFFFF);
      if ($urandom_range(0, 4) == 0) en = ld - $urandom_range(0, 15);
      else en = ld + $urandom_range(1, 250);
      nblk = $urandom_range(0, 3);
      ack_delay = $urandom_range(0, 3); stall_min = ack_delay;
      e_err = (en <= ld);
      e_ev = !e_err && (args >= 3);
      build(args, ld, en, ex, nblk, 1'b0);
      do_load($sformatf("rnd%0d", r), TAP_IDX, img.size(), -1, e_err, e_ev,
              e_ev ? 1 : 0, 16'(ex));
    end

    // Reset while a RAM write is pending, then a clean reload.
    ack_delay = 1000; stall_min = 0;
    g0 = got_q.size();
    build(3, 16'h0400, 16'h040A, 16'h0400, 1, 1'b0);
    ioctl_index = TAP_IDX;
    ioctl_download = 1'b1;
    cyc(2);
    for (int i = 0; i < 147; i++) send_byte(img[i]);
    cyc(2);
    chk("t6_pending", 32'({mem_wr, ioctl_wait, busy, mem_addr}), 32'({3'b111, 16'h0400}));
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_mem", 32'({mem_addr, mem_data, mem_wr}), 32'd0);
    chk("t6_rst_ctl", 32'({exec_addr, ioctl_wait, exec_valid, autostart, busy, err}), 32'd0);
    ioctl_download = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    chk("t6_no_ack", 32'(got_q.size() - g0), 32'd0);
    ack_delay = 0;
    build(3, 16'h0300, 16'h0305, 16'h0300, 1, 1'b1);
    do_load("t6_reload", TAP_IDX, img.size(), -1, 1'b0, 1'b1, 1, 16'h0300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
